// File: rtl/wb_timer_if.sv
// Bus bundle between the hart's data-bus decoder and the machine timer.
// The master drives the access; the timer answers with combinational data and ack.
interface wb_timer_if;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [3:0]  i_wb_sel;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic [31:0] o_wb_data;
  logic        o_wb_ack;

  modport master (
    output i_wb_stb,
    output i_wb_we,
    output i_wb_sel,
    output i_wb_addr,
    output i_wb_data,
    input  o_wb_data,
    input  o_wb_ack
  );

  modport slave (
    input  i_wb_stb,
    input  i_wb_we,
    input  i_wb_sel,
    input  i_wb_addr,
    input  i_wb_data,
    output o_wb_data,
    output o_wb_ack
  );
endinterface

// File: rtl/wb_timer.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp) with prescaler and level interrupt.
// Loads are answered combinationally; stores, counting and the interrupt are registered.
module wb_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic       clk,
  input  logic       rst,
  wb_timer_if.slave  bus,
  output logic       o_irq
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] shadow_hi;
  logic [1:0]  ctrl;
  logic [15:0] ps;

  logic        hit;
  logic        acc;
  logic        wr;
  logic        rd;
  logic [2:0]  off;
  logic        cmp_ge;
  logic [1:0]  ctrl_next;
  logic        en_cnt;
  logic        mtime_wr;
  logic        unused_bits;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++) begin
      if (sel[n]) r[8*n +: 8] = data[8*n +: 8];
    end
    return r;
  endfunction

  assign hit         = (bus.i_wb_addr[31:5] == BASE_ADDR[31:5]);
  assign acc         = bus.i_wb_stb & hit;
  assign wr          = acc & bus.i_wb_we;
  assign rd          = acc & ~bus.i_wb_we;
  assign off         = bus.i_wb_addr[4:2];
  assign cmp_ge      = (mtime >= mtimecmp);
  assign unused_bits = ^bus.i_wb_addr[1:0];
  assign bus.o_wb_ack = acc;

  // A CTRL store that clears EN must also suppress the tick on its own edge,
  // so counting requires EN both before and after this edge.
  assign ctrl_next = (wr && off == 3'd4 && bus.i_wb_sel[0]) ? bus.i_wb_data[1:0] : ctrl;
  assign en_cnt    = ctrl[0] & ctrl_next[0];
  assign mtime_wr  = wr & ((off == 3'd0) | (off == 3'd1));

  always_comb begin
    bus.o_wb_data = 32'h0;
    if (acc) begin
      case (off)
        3'd0:    bus.o_wb_data = mtime[31:0];
        3'd1:    bus.o_wb_data = shadow_hi;
        3'd2:    bus.o_wb_data = mtimecmp[31:0];
        3'd3:    bus.o_wb_data = mtimecmp[63:32];
        3'd4:    bus.o_wb_data = {30'h0, ctrl};
        3'd5:    bus.o_wb_data = {30'h0, o_irq, cmp_ge};
        default: bus.o_wb_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime     <= 64'h0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_hi <= 32'h0;
      ctrl      <= 2'b00;
      ps        <= 16'h0;
      o_irq     <= 1'b0;
    end else begin
      o_irq <= ctrl[1] & cmp_ge;
      ctrl  <= ctrl_next;

      if (rd && off == 3'd0) shadow_hi <= mtime[63:32];

      // A software write to mtime wins over a coincident tick and restarts the prescaler.
      if (mtime_wr) begin
        ps <= 16'h0;
        if (off == 3'd0) mtime[31:0]  <= merge_lanes(mtime[31:0],  bus.i_wb_data, bus.i_wb_sel);
        else             mtime[63:32] <= merge_lanes(mtime[63:32], bus.i_wb_data, bus.i_wb_sel);
      end else if (en_cnt) begin
        if (ps == PS_LAST) begin
          ps    <= 16'h0;
          mtime <= mtime + 64'd1;
        end else begin
          ps <= ps + 16'd1;
        end
      end

      if (wr && off == 3'd2) mtimecmp[31:0]  <= merge_lanes(mtimecmp[31:0],  bus.i_wb_data, bus.i_wb_sel);
      if (wr && off == 3'd3) mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], bus.i_wb_data, bus.i_wb_sel);
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench: two timers (PRESCALE 1 and 4) share one stimulus stream and are
// compared every cycle against a behavioural model of the register map.
module tb_wb_timer;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq1, irq4;
  int   test_count = 0;
  int   fail_count = 0;
  logic [31:0] last_rd1;
  logic [31:0] last_rd4;

  wb_timer_if bus1();
  wb_timer_if bus4();

  wb_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .o_irq(irq1));
  wb_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .o_irq(irq4));

  always #5 clk = ~clk;

  // Reference state, one slot per instance
  logic [63:0] m_time   [2];
  logic [63:0] m_cmp    [2];
  logic [31:0] m_shadow [2];
  logic        m_en     [2];
  logic        m_ie     [2];
  logic        m_irq    [2];
  int          m_ps     [2];
  int          presc    [2] = '{1, 4};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_write(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] sel);
    logic [31:0] r = old;
    for (int n = 0; n < 4; n++) if (sel[n]) r[8*n +: 8] = data[8*n +: 8];
    return r;
  endfunction

  task automatic model_reset(input int i);
    m_time[i] = 64'h0; m_cmp[i] = '1; m_shadow[i] = 32'h0;
    m_en[i] = 1'b0; m_ie[i] = 1'b0; m_irq[i] = 1'b0; m_ps[i] = 0;
  endtask

  function automatic logic [31:0] model_read(input int i, input logic stb, input logic [31:0] addr);
    if (!stb || addr[31:5] != BASE[31:5]) return 32'h0;
    case (addr[4:2])
      3'd0: return m_time[i][31:0];
      3'd1: return m_shadow[i];
      3'd2: return m_cmp[i][31:0];
      3'd3: return m_cmp[i][63:32];
      3'd4: return {30'h0, m_ie[i], m_en[i]};
      3'd5: return {30'h0, m_irq[i], m_time[i] >= m_cmp[i]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input int i, input logic r, input logic stb, input logic we,
                            input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] data);
    logic   acc;
    int     reg_idx;
    logic   irq_next;
    logic   en_next, ie_next;
    if (r) begin
      model_reset(i);
      return;
    end
    acc      = stb && addr[31:5] == BASE[31:5];
    reg_idx  = int'(addr[4:2]);
    irq_next = m_ie[i] && (m_time[i] >= m_cmp[i]);
    en_next  = m_en[i];
    ie_next  = m_ie[i];
    if (acc && !we && reg_idx == 0) m_shadow[i] = m_time[i][63:32];
    if (acc && we && reg_idx == 4 && sel[0]) begin
      en_next = data[0];
      ie_next = data[1];
    end
    if (acc && we && reg_idx == 0) begin
      m_time[i][31:0] = lane_write(m_time[i][31:0], data, sel);
      m_ps[i] = 0;
    end else if (acc && we && reg_idx == 1) begin
      m_time[i][63:32] = lane_write(m_time[i][63:32], data, sel);
      m_ps[i] = 0;
    end else if (m_en[i] && en_next) begin
      m_ps[i] = m_ps[i] + 1;
      if (m_ps[i] == presc[i]) begin
        m_ps[i]   = 0;
        m_time[i] = m_time[i] + 64'd1;
      end
    end
    if (acc && we && reg_idx == 2) m_cmp[i][31:0]  = lane_write(m_cmp[i][31:0],  data, sel);
    if (acc && we && reg_idx == 3) m_cmp[i][63:32] = lane_write(m_cmp[i][63:32], data, sel);
    m_en[i]  = en_next;
    m_ie[i]  = ie_next;
    m_irq[i] = irq_next;
  endtask

  // One bus cycle: drive both timers, check mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input logic r, input logic stb, input logic we, input logic [3:0] sel,
                               input logic [31:0] addr, input logic [31:0] data);
    logic hit;
    rst = r;
    bus1.i_wb_stb = stb; bus1.i_wb_we = we; bus1.i_wb_sel = sel; bus1.i_wb_addr = addr; bus1.i_wb_data = data;
    bus4.i_wb_stb = stb; bus4.i_wb_we = we; bus4.i_wb_sel = sel; bus4.i_wb_addr = addr; bus4.i_wb_data = data;
    #4;
    hit = stb && addr[31:5] == BASE[31:5];
    last_rd1 = bus1.o_wb_data;
    last_rd4 = bus4.o_wb_data;
    checkOutput("ack_p1",  {63'h0, bus1.o_wb_ack}, {63'h0, hit});
    checkOutput("ack_p4",  {63'h0, bus4.o_wb_ack}, {63'h0, hit});
    checkOutput("data_p1", {32'h0, bus1.o_wb_data}, {32'h0, model_read(0, stb, addr)});
    checkOutput("data_p4", {32'h0, bus4.o_wb_data}, {32'h0, model_read(1, stb, addr)});
    checkOutput("irq_p1",  {63'h0, irq1}, {63'h0, m_irq[0]});
    checkOutput("irq_p4",  {63'h0, irq4}, {63'h0, m_irq[1]});
    @(posedge clk);
    model_step(0, r, stb, we, sel, addr, data);
    model_step(1, r, stb, we, sel, addr, data);
    #1;
  endtask

  task automatic store(input logic [4:0] off, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, BASE + {27'h0, off}, data);
  endtask

  task automatic load(input logic [4:0] off);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, BASE + {27'h0, off}, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic        r_stb, r_we, r_rst;
    logic [3:0]  r_sel;
    logic [31:0] r_addr, r_data;

    bus1.i_wb_stb = 1'b0; bus1.i_wb_we = 1'b0; bus1.i_wb_sel = 4'h0; bus1.i_wb_addr = 32'h0; bus1.i_wb_data = 32'h0;
    bus4.i_wb_stb = 1'b0; bus4.i_wb_we = 1'b0; bus4.i_wb_sel = 4'h0; bus4.i_wb_addr = 32'h0; bus4.i_wb_data = 32'h0;
    model_reset(0);
    model_reset(1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Store during reset must be discarded
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, BASE + 32'h08, 32'h0000_0005);
    load(5'h0C);
    checkOutput("rst_cmphi", {32'h0, last_rd1}, 64'hFFFF_FFFF);
    load(5'h08);
    checkOutput("rst_store_dropped", {32'h0, last_rd1}, 64'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, BASE + 32'h20, 32'h0);
    checkOutput("miss_data", {32'h0, last_rd1}, 64'h0);

    // Byte-lane store
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001, BASE + 32'h08, 32'h0000_00AB);
    load(5'h08);
    checkOutput("byte_store", {32'h0, last_rd1}, 64'hFFFF_FFAB);

    // Counting with both prescalers
    store(5'h10, 32'h1);
    idle(40);
    load(5'h00);
    checkOutput("count_p4_range", {63'h0, (last_rd4 >= 32'd9 && last_rd4 <= 32'd11)}, 64'h1);

    // Tear-free read across the 32-bit wrap
    store(5'h10, 32'h0);
    store(5'h00, 32'hFFFF_FFFF);
    store(5'h04, 32'h0);
    store(5'h10, 32'h1);
    load(5'h00);
    idle(2);
    load(5'h04);
    idle(8);
    load(5'h00);
    load(5'h04);
    checkOutput("wrap_hi_p1", {32'h0, last_rd1}, 64'h1);

    // Store coincident with a tick
    store(5'h00, 32'h0000_1234);
    load(5'h00);
    checkOutput("tick_store_p1", {32'h0, last_rd1}, 64'h1234);

    // Interrupt rise and fall
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    store(5'h08, 32'd20);
    store(5'h0C, 32'd0);
    store(5'h10, 32'h3);
    idle(30);
    checkOutput("irq_high_p1", {63'h0, irq1}, 64'h1);
    store(5'h08, 32'd100);
    idle(3);
    checkOutput("irq_low_p1", {63'h0, irq1}, 64'h0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r_rst  = ($urandom_range(0, 99) == 0);
      r_stb  = ($urandom_range(0, 4) != 0);
      r_we   = $urandom_range(0, 1) == 1;
      r_sel  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      r_addr = ($urandom_range(0, 15) == 0) ? BASE + 32'h20 + ($urandom & 32'hFF)
                                             : BASE + {27'h0, 5'($urandom)};
      r_data = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 60));
      applyStimulus(r_rst, r_stb, r_we, r_sel, r_addr, r_data);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end
endmodule
